// File: rtl/sd_lvs_ctrl.sv
// sd_lvs_ctrl: sequencer for the SD low-voltage-signalling identification handshake.
// Build option SD_LVS_MAJORITY_EN: DAT2 decided by strict majority instead of all-high.
module sd_lvs_ctrl #(
  parameter int HOLD_CYCLES   = 1024,
  parameter int PULSE_CYCLES  = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 64,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       lvs_ok,
  output logic       sd_clk,
  output logic       sd_cmd_out,
  output logic       sd_cmd_oe,
  output logic [3:0] sd_dat_out,
  output logic [3:0] sd_dat_oe,
  input  logic [3:0] sd_dat_in
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_PULSE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLE_CYCLES - 1);

`ifdef SD_LVS_MAJORITY_EN
  localparam int ACC_W = $clog2(SAMPLE_CYCLES + 1);
  localparam logic [ACC_W-1:0] ACC_INIT = '0;

  function automatic logic [ACC_W-1:0] acc_next(input logic [ACC_W-1:0] acc, input logic smp);
    return acc + ACC_W'(smp);
  endfunction

  function automatic logic decide(input logic [ACC_W-1:0] acc);
    return (32'(acc) * 32'd2) > 32'(SAMPLE_CYCLES);
  endfunction
`else
  localparam int ACC_W = 1;
  localparam logic [ACC_W-1:0] ACC_INIT = 1'b1;

  function automatic logic [ACC_W-1:0] acc_next(input logic [ACC_W-1:0] acc, input logic smp);
    return acc & smp;
  endfunction

  function automatic logic decide(input logic [ACC_W-1:0] acc);
    return acc[0];
  endfunction
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lvs_q, lvs_d;
  logic             clk_q, clk_d;
  logic             cmd_oe_q, cmd_oe_d;
  logic [3:0]       dat_oe_q, dat_oe_d;
  logic             unused_dat_s;

  // Only DAT2 carries the card's answer; the other DAT inputs are intentionally ignored.
  assign unused_dat_s = ^{sd_dat_in[3], sd_dat_in[1:0]};

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    lvs_d    = lvs_q;
    clk_d    = clk_q;
    cmd_oe_d = cmd_oe_q;
    dat_oe_d = dat_oe_q;
    if ((state_q != ST_IDLE) && abort) begin
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      lvs_d    = 1'b0;
      clk_d    = 1'b0;
      cmd_oe_d = 1'b0;
      dat_oe_d = 4'b0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_d  = ST_HOLD;
            cnt_d    = HOLD_LD;
            busy_d   = 1'b1;
            lvs_d    = 1'b0;
            cmd_oe_d = 1'b1;
            dat_oe_d = 4'b1111;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_d = ST_PULSE;
            cnt_d   = PULSE_LD;
            clk_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
            state_d  = ST_SETTLE;
            cnt_d    = SETTLE_LD;
            clk_d    = 1'b0;
            dat_oe_d = 4'b1011;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = ST_SAMPLE;
            cnt_d   = SAMPLE_LD;
            acc_d   = ACC_INIT;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_SAMPLE: begin
          acc_d = acc_next(acc_q, sd_dat_in[2]);
          if (cnt_q == '0) begin
            // The final sample is folded in before the decision is taken.
            state_d  = ST_FINISH;
            lvs_d    = decide(acc_next(acc_q, sd_dat_in[2]));
            done_d   = 1'b1;
            busy_d   = 1'b0;
            cmd_oe_d = 1'b0;
            dat_oe_d = 4'b0000;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_FINISH: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          lvs_d    = 1'b0;
          clk_d    = 1'b0;
          cmd_oe_d = 1'b0;
          dat_oe_d = 4'b0000;
        end
      endcase
    end
  end

  // State, counter, accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lvs_q    <= 1'b0;
      clk_q    <= 1'b0;
      cmd_oe_q <= 1'b0;
      dat_oe_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      lvs_q    <= lvs_d;
      clk_q    <= clk_d;
      cmd_oe_q <= cmd_oe_d;
      dat_oe_q <= dat_oe_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign lvs_ok     = lvs_q;
  assign sd_clk     = clk_q;
  assign sd_cmd_out = 1'b0;
  assign sd_cmd_oe  = cmd_oe_q;
  assign sd_dat_out = 4'b0000;
  assign sd_dat_oe  = dat_oe_q;

endmodule

// File: tb/tb_sd_lvs_ctrl.sv
// tb_sd_lvs_ctrl: randomized bench for sd_lvs_ctrl against a run-timeline reference model.
// Honours SD_LVS_MAJORITY_EN the same way the design does.
module tb_sd_lvs_ctrl;

  localparam int H   = 1024;
  localparam int P   = 8;
  localparam int S   = 16;
  localparam int M   = 64;
  localparam int SUM = H + P + S + M;
  localparam int WIN = H + P + S;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       lvs_ok;
  logic       sd_clk;
  logic       sd_cmd_out;
  logic       sd_cmd_oe;
  logic [3:0] sd_dat_out;
  logic [3:0] sd_dat_oe;
  logic [3:0] sd_dat_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_done = 0;
  int clk_hi = 0;
  int mode   = 0;
  int glitch = 0;
  bit last_lvs = 1'b0;
  bit prev_clk = 1'b0;

  // reference model: a run is "k edges since acceptance"
  bit m_active = 1'b0;
  int m_k      = 0;
  int m_hi     = 0;
  bit m_lvs    = 1'b0;

  sd_lvs_ctrl #(
    .HOLD_CYCLES(H), .PULSE_CYCLES(P), .SETTLE_CYCLES(S), .SAMPLE_CYCLES(M), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .lvs_ok(lvs_ok), .sd_clk(sd_clk), .sd_cmd_out(sd_cmd_out), .sd_cmd_oe(sd_cmd_oe),
    .sd_dat_out(sd_dat_out), .sd_dat_oe(sd_dat_oe), .sd_dat_in(sd_dat_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit decide(input int hi);
`ifdef SD_LVS_MAJORITY_EN
    return (hi * 2) > M;
`else
    return hi == M;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_hi     <= 0;
      m_lvs    <= 1'b0;
    end else if (!m_active) begin
      if (start && !abort) begin
        m_active <= 1'b1;
        m_k      <= 0;
        m_hi     <= 0;
        m_lvs    <= 1'b0;
      end
    end else if (abort) begin
      m_active <= 1'b0;
      m_lvs    <= 1'b0;
    end else if (m_k == SUM) begin
      m_active <= 1'b0;
    end else begin
      if (m_k >= WIN) m_hi <= m_hi + int'(sd_dat_in[2]);
      m_k <= m_k + 1;
      if (m_k == SUM - 1) m_lvs <= decide(m_hi + int'(sd_dat_in[2]));
    end
  end

  function automatic logic [13:0] exp_vec();
    bit run_on;
    logic [3:0] doe;
    run_on = m_active && (m_k < SUM);
    doe = !run_on ? 4'b0000 : ((m_k < H + P) ? 4'b1111 : 4'b1011);
    return {run_on, m_active && (m_k == SUM), m_lvs, m_active && (m_k >= H) && (m_k < H + P),
            1'b0, run_on, 4'b0000, doe};
  endfunction

  function automatic logic [13:0] act_vec();
    return {busy, done, lvs_ok, sd_clk, sd_cmd_out, sd_cmd_oe, sd_dat_out, sd_dat_oe};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // one clock: compare against the model at the falling edge, then drive DAT inputs
  task automatic step();
    int j;
    @(negedge clk);
    cyc++;
    chk("cycle_outputs", 32'(act_vec()), 32'(exp_vec()));
    if (done === 1'b1) begin
      n_done++;
      last_lvs = lvs_ok;
    end
    if (sd_clk === 1'b1) clk_hi++;
    if (prev_clk && (sd_clk === 1'b0) && (busy === 1'b1))
      chk("oe_at_clk_fall", 32'(sd_dat_oe), 32'h0000000b);
    prev_clk = (sd_clk === 1'b1);
    sd_dat_in = 4'($urandom);
    j = m_k - WIN;
    if (m_active && (m_k >= WIN) && (m_k < SUM)) begin
      case (mode)
        0: sd_dat_in[2] = 1'b1;
        1: sd_dat_in[2] = (j != glitch);
        2: sd_dat_in[2] = (j >= 33);
        default: sd_dat_in[2] = 1'($urandom);
      endcase
    end
  endtask

  task automatic run(input int md, input bit exp_lvs, input string tag);
    int cs;
    int dc;
    bit got;
    mode   = md;
    glitch = $urandom_range(0, M - 1);
    clk_hi = 0;
    got    = 1'b0;
    dc     = 0;
    start  = 1'b1;
    cs     = cyc;
    step();
    start  = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      step();
      if (done === 1'b1) begin
        got = 1'b1;
        dc  = cyc;
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_latency"}, 32'(dc - cs), 32'd1113);
      chk({tag, "_clk_high_cycles"}, 32'(clk_hi), 32'd8);
      if (md <= 2) chk({tag, "_lvs_ok"}, 32'(last_lvs), 32'(exp_lvs));
    end
    step();
  endtask

  initial begin
    int snap;
    int d1;
    int d2;
    bit fin;
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sd_dat_in = 4'b0000;
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", 32'(act_vec()), 32'd0);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) step();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_outputs", 32'(act_vec()), 32'd0);

    run(0, 1'b1, "nominal");
`ifdef SD_LVS_MAJORITY_EN
    run(1, 1'b1, "glitch");
`else
    run(1, 1'b0, "glitch");
`endif
    run(2, 1'b0, "low33");
    run(3, 1'b0, "random_a");
    run(3, 1'b0, "random_b");

    // abort in the middle of the clock pulse
    mode  = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2000 && !(m_active && m_k == H + 3); i++) step();
    chk("abort_reached_pulse", 32'(sd_clk), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_clk", 32'(sd_clk), 32'd0);
    chk("abort_oes", 32'({sd_cmd_oe, sd_dat_oe}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    snap = n_done;
    for (int i = 0; i < 2000; i++) step();
    chk("abort_no_done", 32'(n_done - snap), 32'd0);
    run(0, 1'b1, "after_abort");

    // start pulsed while busy must not queue a second run
    snap  = n_done;
    mode  = 3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 500; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2500; i++) step();
    chk("busy_start_ignored", 32'(n_done - snap), 32'd1);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    step();
    chk("start_abort_busy_later", 32'(busy), 32'd0);

    // start held high: back-to-back runs
    mode  = 0;
    d1    = -1;
    d2    = -1;
    fin   = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3000 && !fin; i++) begin
      step();
      if (done === 1'b1) begin
        if (d1 < 0) d1 = cyc;
        else begin
          d2  = cyc;
          fin = 1'b1;
        end
      end
    end
    start = 1'b0;
    chk("b2b_two_dones", 32'(fin), 32'd1);
    if (fin) chk("b2b_spacing", 32'(d2 - d1), 32'd1114);
    for (int i = 0; i < 5; i++) step();

    // asynchronous reset during the sample window
    mode  = 3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2000 && !(m_active && m_k == WIN + 10); i++) step();
    chk("rst_reached_sample", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_outputs", 32'(act_vec()), 32'd0);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("post_rst_idle", 32'(act_vec()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_lvs_ctrl.md
Name: sd_lvs_ctrl

Overview:
- Sequencer for the SD low-voltage-signalling (LVS) identification handshake on the SD pin datapath (sd_clk, CMD, DAT[3:0]).
- On request it:
  - holds CMD/DAT low;
  - issues one timed sd_clk pulse;
  - releases DAT2;
  - samples DAT2 over a window and reports whether the card signalled LVS support.
- Sits between the bring-up FSM (start/done handshake) and the SB_IO pin cells. Its pin outputs feed D_OUT_0/OUTPUT_ENABLE; sd_dat_in comes from the registered D_IN_0.

Parameters:
- HOLD_CYCLES, 1024, clk cycles CMD/DAT are driven low before the pulse (>=1).
- PULSE_CYCLES, 8, clk cycles sd_clk is held high (>=1).
- SETTLE_CYCLES, 16, clk cycles after DAT2 release that are ignored before sampling (>=1).
- SAMPLE_CYCLES, 64, clk cycles DAT2 is sampled (>=1).
- CNT_W, 16, counter width; must satisfy 2^CNT_W > max of the four cycle parameters.

Ports:
- clk  in  1  block clock; all logic posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  cancel in any state.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at completion.
- lvs_ok  out  1  result; valid from done until next accepted start.
- sd_clk  out  1  SD clock pin level.
- sd_cmd_out  out  1  CMD drive value.
- sd_cmd_oe  out  1  CMD output enable.
- sd_dat_out  out  4  DAT drive values.
- sd_dat_oe  out  4  DAT output enables.
- sd_dat_in  in  4  registered DAT pin inputs.

Behaviour:
- Reset (rst_n low, async): state=IDLE; all outputs 0, including sd_clk, OEs, busy, done and lvs_ok. Pins are released.
- All outputs are registered. A single down-counter cnt[CNT_W-1:0] is shared by all timed states.
- IDLE:
  - Pins are released, sd_clk=0.
  - On start=1 and abort=0: sd_cmd_out=0, sd_cmd_oe=1, sd_dat_out=0, sd_dat_oe=4'b1111, busy=1, lvs_ok=0, cnt=HOLD_CYCLES-1, go to HOLD.
- HOLD:
  - Lines stay driven low.
  - When cnt==0: sd_clk=1, cnt=PULSE_CYCLES-1, go to PULSE. Otherwise decrement cnt.
- PULSE:
  - sd_clk is high for exactly PULSE_CYCLES cycles.
  - When cnt==0: sd_clk=0, sd_dat_oe[2]=0, cnt=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - DAT2 is released; its input is ignored.
  - When cnt==0: cnt=SAMPLE_CYCLES-1, clear the accumulator, go to SAMPLE.
- SAMPLE:
  - Each cycle, accumulate sd_dat_in[2].
  - When cnt==0, the current cycle's sample is included. Go to FINISH.
- FINISH (1 cycle):
  - lvs_ok = decision (see Optional Feature).
  - done=1, busy=0.
  - All OEs=0, outputs 0.
  - Go to IDLE.
- done is high only in the FINISH cycle.
- Latency: start accepted at cycle t gives done at t+HOLD+PULSE+SETTLE+SAMPLE+1 (the cycle count from entering HOLD to done inclusive = sum + 1).
- Boundary rules:
  - start while busy is ignored and not queued.
  - abort in any non-IDLE state: next cycle state=IDLE, sd_clk=0, all OEs=0, busy=0, no done pulse, lvs_ok=0.
  - abort and start in the same IDLE cycle: abort wins, and the start is dropped.
  - start held high continuously: a new run begins in the cycle after FINISH (IDLE accepts it).
  - rst_n asserted mid-run: immediate release of all pins and sd_clk=0.
  - sd_dat_in[3,1,0] and sd_cmd input are never observed.

Optional Feature:
- Macro SD_LVS_MAJORITY_EN.
- Defined: the accumulator is a count of high DAT2 samples, width ceil(log2(SAMPLE_CYCLES+1)). lvs_ok = (count*2 > SAMPLE_CYCLES), i.e. strict majority.
- Undefined: the accumulator is a single AND flag. lvs_ok=1 only if DAT2 was high on every sample cycle.
- Timing, ports and the handshake are identical in both builds.

Test Plan:
- Reset then idle: with rst_n low, all outputs are 0. After release with no start for 100 cycles, outputs stay 0 and busy=0.
- Nominal pass with default parameters and DAT2 tied high once released:
  - done pulses exactly 1+1024+8+16+64 cycles after start.
  - lvs_ok=1.
  - sd_clk is high for exactly 8 cycles.
  - sd_dat_oe goes 1111 to 1011 in the cycle sd_clk falls.
- Fail and glitch: DAT2 high except low for 1 sample-window cycle.
  - Without the macro: lvs_ok=0.
  - With SD_LVS_MAJORITY_EN: lvs_ok=1.
  - With DAT2 low for 33 of 64 cycles, lvs_ok=0 in both builds.
- Abort mid-PULSE: next cycle sd_clk=0, OEs=0, busy=0; no done pulse for 2000 cycles; a fresh start then completes normally.
- Handshake edges:
  - start pulsed while busy causes no extra run.
  - start and abort together in IDLE keep busy=0.
  - start held high gives back-to-back runs with done spaced by the full latency.
- Async reset during SAMPLE: outputs are 0 before the next clk edge, and state returns to IDLE.
